// File: rtl/fact_sched_if.sv
// Bundle between requesters, the round-robin factorial scheduler and the shared engine.
// The scheduler takes the slave side; the requester/engine environment takes the master side.
interface fact_sched_if #(
  parameter int NREQ = 4
);
  logic [NREQ-1:0]   req;
  logic [4*NREQ-1:0] req_data;
  logic [NREQ-1:0]   gnt;
  logic [NREQ-1:0]   rsp_valid;
  logic [15:0]       rsp_fact;
  logic              rsp_ovf;
  logic              rsp_tmo;
  logic              busy;
  logic              eng_start;
  logic [3:0]        eng_data;
  logic              eng_done;
  logic [15:0]       eng_fact;

  modport slave (
    input  req, req_data, eng_done, eng_fact,
    output gnt, rsp_valid, rsp_fact, rsp_ovf, rsp_tmo, busy, eng_start, eng_data
  );

  modport master (
    output req, req_data, eng_done, eng_fact,
    input  gnt, rsp_valid, rsp_fact, rsp_ovf, rsp_tmo, busy, eng_start, eng_data
  );
endinterface

// File: rtl/fact_sched.sv
// Round-robin scheduler sharing one 16-bit factorial engine among NREQ requesters,
// with overflow pre-screen, start/done sequencing and a WAIT timeout.
module fact_sched #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64,
  parameter int MAXN    = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  fact_sched_if.slave  bus
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

  state_t        state;
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic [TW-1:0] timer;

  logic [3:0]      ops [NREQ];
  logic            found;
  logic [IW-1:0]   cand;
  logic [IW-1:0]   win;
  logic [3:0]      win_op;
  logic [NREQ-1:0] win_oh;

  for (genvar g = 0; g < NREQ; g++) begin : g_ops
    assign ops[g] = bus.req_data[4*g +: 4];
  end

  // Search starts just after the last served requester, so it drops to lowest priority.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write, so no latch is inferred.
    found  = 1'b0;
    cand   = '0;
    win    = ptr;
    win_oh = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr) + k) % NREQ);
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
    win_op      = ops[win];
    win_oh[win] = 1'b1;
  end

  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state         <= S_IDLE;
      ptr           <= IW'(NREQ - 1);
      idx           <= '0;
      timer         <= '0;
      bus.gnt       <= '0;
      bus.rsp_valid <= '0;
      bus.rsp_fact  <= '0;
      bus.rsp_ovf   <= 1'b0;
      bus.rsp_tmo   <= 1'b0;
      bus.busy      <= 1'b0;
      bus.eng_start <= 1'b0;
      bus.eng_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      unique case (state)
        S_IDLE: begin
          if (found) begin
            idx      <= win;
            bus.gnt  <= win_oh;
            bus.busy <= 1'b1;
            if (int'(win_op) > MAXN) begin
              // Result would not fit in 16 bits: answer directly, engine untouched.
              state         <= S_RESP;
              bus.rsp_valid <= win_oh;
              bus.rsp_fact  <= '0;
              bus.rsp_ovf   <= 1'b1;
              bus.rsp_tmo   <= 1'b0;
            end else begin
              state         <= S_LAUNCH;
              bus.eng_start <= 1'b1;
              bus.eng_data  <= win_op;
            end
          end
        end

        S_LAUNCH: begin
          // A done seen while start is still high belongs to nothing we launched.
          bus.eng_start <= 1'b0;
          timer         <= '0;
          state         <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.eng_done) begin
            state         <= S_RESP;
            bus.rsp_valid <= bus.gnt;
            bus.rsp_fact  <= bus.eng_fact;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_tmo   <= 1'b0;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state         <= S_RESP;
            bus.rsp_valid <= bus.gnt;
            bus.rsp_fact  <= '0;
            bus.rsp_ovf   <= 1'b0;
            bus.rsp_tmo   <= 1'b1;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        S_RESP: begin
          bus.rsp_valid <= '0;
          bus.rsp_ovf   <= 1'b0;
          bus.rsp_tmo   <= 1'b0;
          bus.gnt       <= '0;
          bus.busy      <= 1'b0;
          ptr           <= idx;
          state         <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fact_sched.sv
// Bench for fact_sched: directed vector table, hand-written multi-cycle sequences,
// and randomized rounds against a round-robin/factorial reference model.
module tb_fact_sched;

  localparam int NREQ = 4;
  localparam int TMO  = 16;
  localparam int MAXN = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  fact_sched_if #(.NREQ(NREQ)) bus ();

  fact_sched #(.NREQ(NREQ), .TIMEOUT(TMO), .MAXN(MAXN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  typedef struct {
    int          idx;
    int          n;
    int          d;     // engine delay; -1 = engine never answers
    logic [15:0] fact;
    logic        ovf;
    logic        tmo;
    int          lat;   // cycles from request cycle to response cycle, both counted
  } vec_t;

  vec_t vecs [9];

  int n_vec = 0;
  int n_err = 0;

  int         eng_delay = 1;  // -1 mute, 0 random 1..17, >0 fixed
  int         dq [$];
  int         start_cnt = 0;
  logic [3:0] start_data = '0;

  function automatic logic [15:0] fact16(input int n);
    longint r;
    r = 1;
    for (int i = 2; i <= n; i++) r = r * i;
    return r[15:0];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Engine model: answers n! a chosen number of cycles after seeing start.
  initial begin : engine
    int e_n;
    int e_d;
    bus.eng_done = 1'b0;
    bus.eng_fact = '0;
    forever begin
      @(negedge clk);
      if (bus.eng_start === 1'b1 && eng_delay >= 0) begin
        e_n = int'(bus.eng_data);
        e_d = (eng_delay == 0) ? int'($urandom_range(1, 17)) : eng_delay;
        dq.push_back(e_d);
        repeat (e_d) @(negedge clk);
        bus.eng_fact = fact16(e_n);
        bus.eng_done = 1'b1;
        @(negedge clk);
        bus.eng_done = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (bus.eng_start === 1'b1) begin
      start_cnt  <= start_cnt + 1;
      start_data <= bus.eng_data;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_rsp(input int budget, output logic [3:0] rv, output int lat,
                          output logic [3:0] g1);
    lat = 1;
    rv  = '0;
    g1  = '0;
    while (rv == 0 && lat <= budget) begin
      @(negedge clk);
      lat++;
      if (lat == 2) g1 = bus.gnt;
      if (!$onehot0(bus.gnt)) check("gnt_onehot", 32'(bus.gnt), 32'd0);
      rv = bus.rsp_valid;
    end
    if (rv == 0) check("rsp_wait_expired", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    reset_n = 1'b0;
  endtask

  initial begin : main
    logic [3:0]  rv;
    logic [3:0]  g1;
    int          lat;
    int          s0;
    int          ord [5];
    logic [15:0] ofact [5];

    vecs[0] = '{0,  6,  5, 16'h02D0, 1'b0, 1'b0,  8};
    vecs[1] = '{2,  0,  3, 16'd1,    1'b0, 1'b0,  6};
    vecs[2] = '{2,  8,  4, 16'h9D80, 1'b0, 1'b0,  7};
    vecs[3] = '{1,  9,  0, 16'd0,    1'b1, 1'b0,  2};
    vecs[4] = '{3, 15,  0, 16'd0,    1'b1, 1'b0,  2};
    vecs[5] = '{1,  1,  1, 16'd1,    1'b0, 1'b0,  4};
    vecs[6] = '{0,  7, 16, 16'd5040, 1'b0, 1'b0, 19};  // done in the timeout cycle
    vecs[7] = '{3,  5, -1, 16'd0,    1'b0, 1'b1, 19};  // engine silent
    vecs[8] = '{2,  3,  2, 16'd6,    1'b0, 1'b0,  5};  // normal after timeout

    bus.req      = '0;
    bus.req_data = '0;
    repeat (2) @(negedge clk);
    check("rst_gnt",       32'(bus.gnt),       32'd0);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_fact",  32'(bus.rsp_fact),  32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
    check("rst_eng_start", 32'(bus.eng_start), 32'd0);
    check("rst_eng_data",  32'(bus.eng_data),  32'd0);
    reset_n = 1'b0;

    // Directed single-requester table.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      eng_delay = vecs[i].d;
      s0 = start_cnt;
      bus.req_data[4*vecs[i].idx +: 4] = 4'(vecs[i].n);
      bus.req = 4'(1) << vecs[i].idx;
      wait_rsp(40, rv, lat, g1);
      check($sformatf("v%0d_gnt", i),     32'(g1),           32'(4'(1) << vecs[i].idx));
      check($sformatf("v%0d_valid", i),   32'(rv),           32'(4'(1) << vecs[i].idx));
      check($sformatf("v%0d_fact", i),    32'(bus.rsp_fact), 32'(vecs[i].fact));
      check($sformatf("v%0d_ovf", i),     32'(bus.rsp_ovf),  32'(vecs[i].ovf));
      check($sformatf("v%0d_tmo", i),     32'(bus.rsp_tmo),  32'(vecs[i].tmo));
      check($sformatf("v%0d_latency", i), 32'(lat),          32'(vecs[i].lat));
      check($sformatf("v%0d_starts", i),  32'(start_cnt - s0), vecs[i].ovf ? 32'd0 : 32'd1);
      if (!vecs[i].ovf)
        check($sformatf("v%0d_eng_data", i), 32'(start_data), 32'(vecs[i].n));
      bus.req = '0;
      @(negedge clk);
      check($sformatf("v%0d_valid_off", i), 32'(bus.rsp_valid), 32'd0);
      check($sformatf("v%0d_gnt_off", i),   32'(bus.gnt),       32'd0);
      check($sformatf("v%0d_busy_off", i),  32'(bus.busy),      32'd0);
      check($sformatf("v%0d_fact_hold", i), 32'(bus.rsp_fact),  32'(vecs[i].fact));
    end

    // All four held: strict round-robin 0,1,2,3,0.
    do_reset();
    eng_delay = 2;
    ord   = '{0, 1, 2, 3, 0};
    ofact = '{16'd1, 16'd2, 16'd6, 16'd24, 16'd1};
    @(negedge clk);
    bus.req_data = {4'd4, 4'd3, 4'd2, 4'd1};
    bus.req      = 4'hF;
    for (int k = 0; k < 5; k++) begin
      wait_rsp(40, rv, lat, g1);
      check($sformatf("rr%0d_valid", k), 32'(rv),           32'(4'(1) << ord[k]));
      check($sformatf("rr%0d_fact", k),  32'(bus.rsp_fact), 32'(ofact[k]));
    end
    bus.req = '0;
    @(negedge clk);

    // Reset in the middle of WAIT.
    eng_delay = -1;
    @(negedge clk);
    bus.req_data = {4'd2, 4'd0, 4'd4, 4'd3};
    bus.req      = 4'b0010;
    repeat (6) @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'd1);
    #1 reset_n = 1'b1;
    #1;
    check("arst_gnt",       32'(bus.gnt),       32'd0);
    check("arst_busy",      32'(bus.busy),      32'd0);
    check("arst_eng_data",  32'(bus.eng_data),  32'd0);
    check("arst_eng_start", 32'(bus.eng_start), 32'd0);
    check("arst_rsp",       32'({bus.rsp_valid, bus.rsp_fact, bus.rsp_ovf, bus.rsp_tmo}), 32'd0);
    bus.req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("arst_no_valid", 32'(bus.rsp_valid), 32'd0);
    end
    eng_delay = 2;
    reset_n   = 1'b0;
    @(negedge clk);
    check("post_rst_gnt", 32'(bus.gnt), 32'b0001);
    wait_rsp(40, rv, lat, g1);
    check("post_rst_valid0", 32'(rv),           32'b0001);
    check("post_rst_fact0",  32'(bus.rsp_fact), 32'd6);
    bus.req[0] = 1'b0;
    wait_rsp(40, rv, lat, g1);
    check("post_rst_valid3", 32'(rv),           32'b1000);
    check("post_rst_fact3",  32'(bus.rsp_fact), 32'd2);
    bus.req = '0;

    // Randomized rounds against a round-robin / factorial reference model.
    do_reset();
    dq.delete();
    eng_delay = 0;
    begin : random_phase
      int          p;
      int          e;
      int          d;
      int          ops [NREQ];
      logic [3:0]  mask;
      bit          rem [NREQ];
      int          left;
      logic        x_ovf;
      logic        x_tmo;
      logic [15:0] x_fact;
      p = NREQ - 1;
      for (int r = 0; r < 30; r++) begin
        @(negedge clk);
        mask = 4'($urandom_range(1, 15));
        left = 0;
        for (int i = 0; i < NREQ; i++) begin
          ops[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15))
                                               : int'($urandom_range(0, 8));
          bus.req_data[4*i +: 4] = 4'(ops[i]);
          rem[i] = mask[i];
          if (mask[i]) left++;
        end
        bus.req = mask;
        while (left > 0) begin
          e = -1;
          for (int k = 1; k <= NREQ; k++)
            if (e < 0 && rem[(p + k) % NREQ]) e = (p + k) % NREQ;
          wait_rsp(60, rv, lat, g1);
          x_ovf = (ops[e] > MAXN);
          x_tmo = 1'b0;
          if (!x_ovf) begin
            if (dq.size() == 0) begin
              check("rnd_engine_launch", 32'd0, 32'd1);
              d = 1;
            end else begin
              d = dq.pop_front();
            end
            x_tmo = (d > TMO);
          end
          x_fact = (x_ovf || x_tmo) ? 16'd0 : fact16(ops[e]);
          check($sformatf("rnd%0d_valid", r), 32'(rv),           32'(4'(1) << e));
          check($sformatf("rnd%0d_fact", r),  32'(bus.rsp_fact), 32'(x_fact));
          check($sformatf("rnd%0d_ovf", r),   32'(bus.rsp_ovf),  32'(x_ovf));
          check($sformatf("rnd%0d_tmo", r),   32'(bus.rsp_tmo),  32'(x_tmo));
          bus.req[e] = 1'b0;
          rem[e] = 1'b0;
          left--;
          p = e;
        end
        @(negedge clk);
        check($sformatf("rnd%0d_idle_gnt", r), 32'(bus.gnt), 32'd0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fact_sched.md
Name: fact_sched

Overview:
- Round-robin scheduler that shares one 16-bit factorial engine among NREQ requesters.
- Arbitrates the requests and latches the winner's 4-bit operand.
- Pre-screens operands that would overflow, sequences the engine start/done handshake with a timeout, and returns the result to the granted requester.
- Sits between the requester blocks and the single factorial engine instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles spent in WAIT for eng_done before aborting (>=2).
- MAXN, 8, largest operand dispatched; 8! = 40320 is the largest factorial that fits in 16 bits.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-high reset (1 = reset asserted).
- req  in  NREQ  level request per requester; held until that requester's rsp_valid.
- req_data  in  4*NREQ  operand n per requester; slice i = bits [4i+3:4i]; valid while req[i]=1.
- gnt  out  NREQ  one-hot grant; high from grant until the response cycle.
- rsp_valid  out  NREQ  one-cycle pulse to the served requester.
- rsp_fact  out  16  result; valid while any rsp_valid bit is high.
- rsp_ovf  out  1  operand > MAXN; valid with rsp_valid.
- rsp_tmo  out  1  engine timeout; valid with rsp_valid.
- busy  out  1  high in every state except IDLE.
- eng_start  out  1  one-cycle start pulse to the engine.
- eng_data  out  4  operand to the engine.
- eng_done  in  1  engine completion.
- eng_fact  in  16  engine result.

Behaviour:
- Reset (asynchronous, while reset_n=1):
  - State = IDLE.
  - All outputs = 0: gnt, rsp_valid, rsp_fact, rsp_ovf, rsp_tmo, busy, eng_start, eng_data.
  - Round-robin pointer = NREQ-1, so requester 0 has first priority.
  - Timer = 0.
  - Reset mid-operation abandons the transaction; no rsp_valid is produced.
- All outputs are registered.
- IDLE:
  - When req != 0, select the first set bit searching from (ptr+1) mod NREQ upward with wrap-around.
  - Latch index and operand; set gnt and busy on the next edge.
  - If operand > MAXN, go to RESP with ovf=1 and result 0; the engine is never touched.
  - Otherwise go to LAUNCH.
- LAUNCH (one cycle):
  - eng_start=1; eng_data = latched operand; timer cleared.
  - eng_done is ignored in this state.
  - Go to WAIT.
- WAIT:
  - eng_data is held stable; eng_start=0.
  - eng_done=1: capture eng_fact, go to RESP.
  - Otherwise timer increments. When timer reaches TIMEOUT-1 without done, go to RESP with tmo=1 and result 0.
  - eng_done arriving in the same cycle as the timeout: done wins, tmo=0.
- RESP (one cycle):
  - rsp_valid[idx]=1 together with rsp_fact, rsp_ovf, rsp_tmo.
  - gnt cleared; ptr = idx; next state IDLE.
  - rsp_valid, rsp_ovf and rsp_tmo return to 0 on the next edge; rsp_fact holds its value.
- Arbitration in IDLE uses req as sampled in that cycle. A new request can therefore be granted the cycle after RESP.
- A request dropped during service does not cancel it: the service completes and rsp_valid still pulses.
- A requester still holding req after its rsp_valid competes again at lowest priority.
- Operand 0 is dispatched to the engine normally; expected result is 1.
- Latency for operand <= MAXN, with the engine asserting done D cycles after eng_start: req-to-rsp_valid = 3 + D cycles.
- Ovf path latency: req-to-rsp_valid = 2 cycles.

Test Plan:
- Reset, then req[0]=1 with n=6 and an engine model returning 720 after 5 cycles -> gnt=0001, one eng_start pulse with eng_data=6, rsp_valid=0001 with rsp_fact=16'h02D0, ovf=0, tmo=0.
- req[2]=1 with n=0 -> rsp_fact=1 on rsp_valid=0100; n=8 -> rsp_fact=40320 (16'h9D80).
- req[1]=1 with n=9 -> no eng_start, rsp_valid=0010 two cycles after req, rsp_ovf=1, rsp_fact=0.
- All four req high and held -> grants in order 0,1,2,3,0; each gnt strictly one-hot; no overlap between services.
- TIMEOUT=16 with eng_done tied 0 -> rsp_tmo=1 and rsp_fact=0 after 16 cycles in WAIT; the next request is served normally. Done coincident with the timeout cycle -> tmo=0 and the result is taken.
- Assert reset_n mid-WAIT -> all outputs 0 immediately (asynchronous), no rsp_valid. After release, requester 0 wins over simultaneous requests from 0 and 3.
